// File: rtl/button_debouncer.sv
// button_debouncer: conditions one synchronized pushbutton.
// Produces a debounced level plus registered one-cycle press/release strobes.
// Debounce and hold timing count the shared 1 kHz 'tick' strobe, not raw clocks.
// Optional auto-repeat is compiled in with the macro BTN_AUTOREPEAT_EN. When it
// is left undefined, repeat_pulse is tied low and step_pulse equals press_pulse.
module button_debouncer #(
    parameter int DB_TICKS     = 20,
    parameter int HOLD_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_sync,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic step_pulse
);

    localparam int DBW = $clog2(DB_TICKS + 1);
    // db_cnt value seen on the tick that completes the debounce window
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    state_t         state;
    logic [DBW-1:0] db_cnt;

`ifdef BTN_AUTOREPEAT_EN
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    // Reloading to HOLD-REPEAT makes later strobes arrive every REPEAT ticks.
    // If REPEAT >= HOLD the reload saturates at 0, so the period becomes HOLD.
    localparam logic [HW-1:0] HOLD_RELOAD =
        (REPEAT_TICKS >= HOLD_TICKS) ? '0 : HW'(HOLD_TICKS - REPEAT_TICKS);

    logic [HW-1:0] hold_cnt;
`else
    // The repeat logic is compiled out, so nothing can ever strobe here.
    assign repeat_pulse = 1'b0;
`endif

    // Reject parameter values that would break the tick arithmetic.
    if (DB_TICKS < 1) begin : g_chk_db
        $error("DB_TICKS must be >= 1");
    end
    if (HOLD_TICKS < 1) begin : g_chk_hold
        $error("HOLD_TICKS must be >= 1");
    end
    if (REPEAT_TICKS < 1) begin : g_chk_repeat
        $error("REPEAT_TICKS must be >= 1");
    end

    // Debounce FSM. All outputs are registered, and the strobes default low
    // every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            db_cnt        <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step_pulse    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            hold_cnt      <= '0;
            repeat_pulse  <= 1'b0;
`endif
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step_pulse    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            repeat_pulse  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    // A bounce takes priority over a tick in the same cycle.
                    if (!btn_sync) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (tick) begin
                        if (db_cnt == DB_LAST) begin
                            state       <= PRESSED;
                            db_cnt      <= '0;
                            level       <= 1'b1;
                            press_pulse <= 1'b1;
                            step_pulse  <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            hold_cnt    <= '0;
`endif
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt     <= HOLD_RELOAD;
                            repeat_pulse <= 1'b1;
                            step_pulse   <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
`endif
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed resumes the hold count where it
                    // stopped, and it gives no fresh press strobe.
                    if (btn_sync) begin
                        state  <= PRESSED;
                        db_cnt <= '0;
                    end else if (tick) begin
                        if (db_cnt == DB_LAST) begin
                            state         <= IDLE;
                            db_cnt        <= '0;
                            level         <= 1'b0;
                            release_pulse <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                            hold_cnt      <= '0;
`endif
                        end else begin
                            db_cnt <= db_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    db_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Testbench for button_debouncer. It uses DB_TICKS=3, HOLD_TICKS=10 and
// REPEAT_TICKS=4, with a tick every 10 clocks. The stimulus pushes each
// expected strobe, stamped with its tick number, into a queue. A monitor pops
// an entry whenever a strobe appears and compares it.
`timescale 1ns/1ps
module tb_button_debouncer;

    localparam int DB   = 3;
    localparam int HOLD = 10;
    localparam int REP  = 4;
`ifdef BTN_AUTOREPEAT_EN
    localparam int N_REP = 6;
`else
    localparam int N_REP = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic btn_sync = 1'b0;
    logic level, press_pulse, release_pulse, repeat_pulse, step_pulse;

    button_debouncer #(
        .DB_TICKS(DB),
        .HOLD_TICKS(HOLD),
        .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .btn_sync(btn_sync),
        .level(level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit press;
        bit rel;
        bit rep;
        bit step;
        bit lvl;
        int tno;
    } ev_t;

    ev_t expq[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  tcount = 0;
    int  step_cnt = 0;
    int  rep_cnt = 0;

    // The tick is high for one clock in every ten. It changes on the falling edge.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 10;
            tick = (ph == 0);
        end
    end

    // The monitor counts tick edges and checks every strobe against the queue.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            if (tick === 1'b1) tcount++;
            if (press_pulse === 1'b1 || release_pulse === 1'b1 ||
                repeat_pulse === 1'b1 || step_pulse === 1'b1) begin
                if (step_pulse === 1'b1) step_cnt++;
                if (repeat_pulse === 1'b1) rep_cnt++;
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_strobe: got lvl/prs/rel/rep/stp=%b%b%b%b%b at tick %0d, required no strobe",
                             level, press_pulse, release_pulse, repeat_pulse, step_pulse, tcount);
                end else begin
                    e = expq.pop_front();
                    if (press_pulse !== e.press || release_pulse !== e.rel ||
                        repeat_pulse !== e.rep || step_pulse !== e.step ||
                        level !== e.lvl || tick !== 1'b1 || tcount != e.tno) begin
                        miscompares++;
                        $display("FAIL strobe: got lvl/prs/rel/rep/stp=%b%b%b%b%b tick=%b tno=%0d, required %b%b%b%b%b tick=1 tno=%0d",
                                 level, press_pulse, release_pulse, repeat_pulse, step_pulse, tick, tcount,
                                 e.lvl, e.press, e.rel, e.rep, e.step, e.tno);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] outs();
        return {level, press_pulse, release_pulse, repeat_pulse, step_pulse};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got lvl/prs/rel/rep/stp=%b, required %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic step_clk();
        @(negedge clk);
        #1;
    endtask

    // Returns just after the n-th further tick edge. The next tick is then
    // about 9 clocks away.
    task automatic wait_ticks(input int n);
        int target;
        int guard;
        target = tcount + n;
        guard = 0;
        while (tcount < target && guard < 20 * n + 20) begin
            step_clk();
            guard++;
        end
        if (tcount < target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_ticks: got tick %0d, required %0d", tcount, target);
        end
    endtask

    task automatic expect_ev(input bit p, input bit r, input bit rp, input bit s,
                             input bit l, input int tno);
        ev_t e;
        e.press = p;
        e.rel   = r;
        e.rep   = rp;
        e.step  = s;
        e.lvl   = l;
        e.tno   = tno;
        expq.push_back(e);
    endtask

    initial begin
        int t;
        int base_step;
        int base_rep;
        int guard;

        // Hold reset for 3 clocks with the button pressed. All outputs must stay low.
        reset = 1'b0;
        btn_sync = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            chk($sformatf("reset_cyc%0d", i), outs(), 5'b00000);
        end
        wait_ticks(1);

        // First press after reset, then hold for 30 ticks (auto-repeat if built in).
        reset = 1'b1;
        t = tcount;
        base_step = step_cnt;
        base_rep = rep_cnt;
        expect_ev(1, 0, 0, 1, 1, t + 3);
`ifdef BTN_AUTOREPEAT_EN
        for (int k = 0; k < 6; k++) expect_ev(0, 0, 1, 1, 1, t + 3 + 10 + 4 * k);
`endif
        wait_ticks(3);
        chk("press_strobe", outs(), 5'b11001);
        step_clk();
        chk("press_one_cycle", outs(), 5'b10000);
        wait_ticks(30);
        chk_int("hold_step_count", step_cnt - base_step, 1 + N_REP);
        chk_int("hold_repeat_count", rep_cnt - base_rep, N_REP);

        // Clean release.
        btn_sync = 1'b0;
        t = tcount;
        expect_ev(0, 1, 0, 0, 0, t + 3);
        wait_ticks(3);
        chk("release_strobe", outs(), 5'b00100);
        step_clk();
        chk("release_one_cycle", outs(), 5'b00000);
        wait_ticks(1);

        // Press bounce: 2 ticks high, 1 clock low, then a full 3 ticks again.
        btn_sync = 1'b1;
        wait_ticks(2);
        btn_sync = 1'b0;
        step_clk();
        btn_sync = 1'b1;
        t = tcount;
        expect_ev(1, 0, 0, 1, 1, t + 3);
        wait_ticks(3);
        chk("bounce_press", outs(), 5'b11001);

        // Release bounce: there must be no second press and no early release.
        btn_sync = 1'b0;
        wait_ticks(2);
        btn_sync = 1'b1;
        step_clk();
        btn_sync = 1'b0;
        t = tcount;
        expect_ev(0, 1, 0, 0, 0, t + 3);
        wait_ticks(3);
        chk("bounce_release", outs(), 5'b00100);

        // The button drops on the same clock as the 3rd qualifying tick.
        btn_sync = 1'b1;
        wait_ticks(2);
        guard = 0;
        while (tick !== 1'b1 && guard < 20) begin
            step_clk();
            guard++;
        end
        btn_sync = 1'b0;
        step_clk();
        chk("coincident_drop", outs(), 5'b00000);
        wait_ticks(3);
        chk("coincident_idle", outs(), 5'b00000);

        // Reset in the middle of a hold. It gives no release strobe, and a full
        // re-debounce is needed afterwards.
        btn_sync = 1'b1;
        t = tcount;
        expect_ev(1, 0, 0, 1, 1, t + 3);
        wait_ticks(3 + 5);
        chk("midhold_level", outs(), 5'b10000);
        reset = 1'b0;
        step_clk();
        chk("reset_midhold", outs(), 5'b00000);
        reset = 1'b1;
        t = tcount;
        expect_ev(1, 0, 0, 1, 1, t + 3);
        wait_ticks(2);
        chk("repress_wait", outs(), 5'b00000);
        wait_ticks(1);
        chk("repress_strobe", outs(), 5'b11001);
        btn_sync = 1'b0;
        t = tcount;
        expect_ev(0, 1, 0, 0, 0, t + 3);
        wait_ticks(3);
        chk("final_release", outs(), 5'b00100);

        for (int i = 0; i < 5; i++) step_clk();
        chk_int("pending_expected", expq.size(), 0);
        chk_int("total_steps", step_cnt, 4 + N_REP);
        chk_int("total_repeats", rep_cnt, N_REP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
